// File: rtl/exec_mon_pkg.sv
// Shared definitions for the execution-window monitor: result flags, FSM states
// and the default counter width.
package exec_mon_pkg;

   localparam int unsigned CNT_W_DEF = 32;

   localparam logic [1:0] FLAG_OK      = 2'b00;
   localparam logic [1:0] FLAG_SHORT   = 2'b01;
   localparam logic [1:0] FLAG_LONG    = 2'b10;
   localparam logic [1:0] FLAG_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      REPORT = 2'd2
   } state_e;

endpackage

// File: rtl/exec_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1 with wrap-around. The pointer register is owned by the parent.
module exec_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [ID_W-1:0]    win_id,
   output logic               any
);

   always_comb begin
      int unsigned idx;
      win_onehot = '0;
      win_id     = '0;
      any        = 1'b0;
      idx        = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = (32'(ptr) + i) % NUM_REQ;
         if (!any && req[ID_W'(idx)]) begin
            any                     = 1'b1;
            win_id                  = ID_W'(idx);
            win_onehot[ID_W'(idx)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/exec_window_ctrl.sv
// Shares one cycle-measurement engine between requesters: measures grant-to-done
// cycles, classifies against latched bounds/timeout and reports via valid/ready.
module exec_window_ctrl
   import exec_mon_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ),
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic               in_clk,
   input  logic               in_reset_n,
   input  logic [NUM_REQ-1:0] in_req,
   input  logic [NUM_REQ-1:0] in_done,
   input  logic [CNT_W-1:0]   in_lo_bound,
   input  logic [CNT_W-1:0]   in_hi_bound,
   input  logic [CNT_W-1:0]   in_timeout,
   output logic [NUM_REQ-1:0] out_gnt,
   output logic               out_busy,
   output logic               out_res_valid,
   input  logic               in_res_ready,
   output logic [ID_W-1:0]    out_res_id,
   output logic [CNT_W-1:0]   out_res_cycles,
   output logic [1:0]         out_res_flag
);

   state_e               state;
   logic [ID_W-1:0]      ptr;
   logic [ID_W-1:0]      id;
   logic [NUM_REQ-1:0]   gnt_sel;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     lo;
   logic [CNT_W-1:0]     hi;
   logic [CNT_W-1:0]     tmo;

   logic [NUM_REQ-1:0]   arb_onehot;
   logic [ID_W-1:0]      arb_id;
   logic                 arb_any;
   logic                 req_hit;
   logic                 done_hit;
   logic                 tmo_hit;
   logic [1:0]           cls;

   exec_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req        (in_req),
      .ptr        (ptr),
      .win_onehot (arb_onehot),
      .win_id     (arb_id),
      .any        (arb_any)
   );

   assign out_gnt  = (state == RUN) ? gnt_sel : '0;
   assign out_busy = (state != IDLE);
   assign req_hit  = |(in_req & gnt_sel);
   assign done_hit = |(in_done & gnt_sel);
   assign tmo_hit  = (tmo != '0) && (cnt == tmo);

   always_comb begin
      if (cnt > hi)
         cls = FLAG_LONG;
      else if (cnt < lo)
         cls = FLAG_SHORT;
      else
         cls = FLAG_OK;
   end

   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state          <= IDLE;
         ptr            <= ID_W'(NUM_REQ - 1);
         id             <= '0;
         gnt_sel        <= '0;
         cnt            <= '0;
         lo             <= '0;
         hi             <= '0;
         tmo            <= '0;
         out_res_valid  <= 1'b0;
         out_res_id     <= '0;
         out_res_cycles <= '0;
         out_res_flag   <= FLAG_OK;
      end else begin
         case (state)
            IDLE: begin
               if (arb_any) begin
                  id      <= arb_id;
                  gnt_sel <= arb_onehot;
                  lo      <= in_lo_bound;
                  hi      <= in_hi_bound;
                  tmo     <= in_timeout;
                  cnt     <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               // A dropped request aborts even if done arrives in the same cycle
               if (!req_hit) begin
                  ptr   <= id;
                  state <= IDLE;
               end else if (done_hit) begin
                  out_res_id     <= id;
                  out_res_cycles <= cnt;
                  out_res_flag   <= cls;
                  out_res_valid  <= 1'b1;
                  state          <= REPORT;
               end else if (tmo_hit) begin
                  out_res_id     <= id;
                  out_res_cycles <= tmo;
                  out_res_flag   <= FLAG_TIMEOUT;
                  out_res_valid  <= 1'b1;
                  state          <= REPORT;
               end else if (cnt != '1) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            REPORT: begin
               if (in_res_ready) begin
                  out_res_valid <= 1'b0;
                  ptr           <= id;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_window_ctrl.sv
// Scoreboard bench for exec_window_ctrl: directed stimulus pushes hand-computed
// results; a negedge monitor pops and compares on each valid/ready handshake.
module tb_exec_window_ctrl;
   import exec_mon_pkg::*;

   logic        in_clk = 1'b0;
   logic        in_reset_n;
   logic [3:0]  in_req;
   logic [3:0]  in_done;
   logic [31:0] in_lo_bound;
   logic [31:0] in_hi_bound;
   logic [31:0] in_timeout;
   logic [3:0]  out_gnt;
   logic        out_busy;
   logic        out_res_valid;
   logic        in_res_ready;
   logic [1:0]  out_res_id;
   logic [31:0] out_res_cycles;
   logic [1:0]  out_res_flag;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] cycles;
      logic [1:0]  flag;
   } res_t;

   res_t exp_q[$];
   res_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   exec_window_ctrl #(
      .NUM_REQ (4),
      .ID_W    (2),
      .CNT_W   (32)
   ) dut (
      .in_clk         (in_clk),
      .in_reset_n     (in_reset_n),
      .in_req         (in_req),
      .in_done        (in_done),
      .in_lo_bound    (in_lo_bound),
      .in_hi_bound    (in_hi_bound),
      .in_timeout     (in_timeout),
      .out_gnt        (out_gnt),
      .out_busy       (out_busy),
      .out_res_valid  (out_res_valid),
      .in_res_ready   (in_res_ready),
      .out_res_id     (out_res_id),
      .out_res_cycles (out_res_cycles),
      .out_res_flag   (out_res_flag)
   );

   always #5 in_clk = ~in_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic push_exp(input int unsigned r, input int unsigned c, input logic [1:0] f);
      res_t e;
      e.id     = 2'(r);
      e.cycles = 32'(c);
      e.flag   = f;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input int unsigned max_cyc);
      int unsigned n = 0;
      while (out_busy && n < max_cyc) begin
         tick();
         n++;
      end
      check("idle_wait", 32'(out_busy), 32'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_gnt",    32'(out_gnt),       32'd0);
      check("rst_busy",   32'(out_busy),      32'd0);
      check("rst_valid",  32'(out_res_valid), 32'd0);
      check("rst_id",     32'(out_res_id),    32'd0);
      check("rst_cycles", out_res_cycles,     32'd0);
      check("rst_flag",   32'(out_res_flag),  32'd0);
   endtask

   // grant requester r, let k done-free RUN cycles pass, then pulse done (ready high)
   task automatic measure(input int unsigned r, input int unsigned k, input logic [1:0] f);
      in_req[r] = 1'b1;
      check("gnt_before_edge", 32'(out_gnt), 32'd0);
      tick();
      check("gnt_run", 32'(out_gnt), 32'd1 << r);
      check("busy_run", 32'(out_busy), 32'd1);
      repeat (k) tick();
      in_done[r] = 1'b1;
      push_exp(r, k, f);
      tick();
      in_done[r] = 1'b0;
      in_req[r]  = 1'b0;
      check("gnt_report", 32'(out_gnt), 32'd0);
      check("valid_report", 32'(out_res_valid), 32'd1);
      wait_idle(10);
   endtask

   always @(negedge in_clk) begin
      if (in_reset_n && out_res_valid && in_res_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got id %0d cycles %0d flag %0d, expected none",
                     out_res_id, out_res_cycles, out_res_flag);
         end else begin
            mon_e = exp_q.pop_front();
            check("res_id",     32'(out_res_id),   32'(mon_e.id));
            check("res_cycles", out_res_cycles,    mon_e.cycles);
            check("res_flag",   32'(out_res_flag), 32'(mon_e.flag));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_reset_n   = 1'b0;
      in_req       = '0;
      in_done      = '0;
      in_lo_bound  = 32'd5;
      in_hi_bound  = 32'd10;
      in_timeout   = 32'd0;
      in_res_ready = 1'b1;
      repeat (2) @(posedge in_clk);
      #1;
      check_reset_outputs();
      in_reset_n = 1'b1;
      tick();

      // single measurement in window: 7 cycles, OK
      measure(0, 7, FLAG_OK);

      // full contention after reset: rotation 0,1,2,3,0, all immediate (SHORT)
      in_reset_n = 1'b0;
      tick();
      in_reset_n = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) push_exp(k % 4, 0, FLAG_SHORT);
      in_req  = 4'b1111;
      in_done = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_gnt", 32'(out_gnt), 32'd1 << (k % 4));
         tick();
         tick();
      end
      in_req  = '0;
      in_done = '0;
      wait_idle(10);

      // timeout at 20 with done never asserted
      in_timeout = 32'd20;
      in_req[1]  = 1'b1;
      tick();
      check("tmo_gnt", 32'(out_gnt), 32'b0010);
      repeat (20) tick();
      check("tmo_gnt_last_run", 32'(out_gnt), 32'b0010);
      push_exp(1, 20, FLAG_TIMEOUT);
      tick();
      check("tmo_gnt_report", 32'(out_gnt), 32'd0);
      check("tmo_valid", 32'(out_res_valid), 32'd1);
      in_req     = '0;
      in_timeout = 32'd0;
      wait_idle(10);

      // LONG result with ready held low for 5 cycles, request kept high
      in_res_ready = 1'b0;
      in_req[2]    = 1'b1;
      tick();
      check("long_gnt", 32'(out_gnt), 32'b0100);
      repeat (12) tick();
      in_done[2] = 1'b1;
      push_exp(2, 12, FLAG_LONG);
      tick();
      in_done[2] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("hold_valid",  32'(out_res_valid), 32'd1);
         check("hold_id",     32'(out_res_id),    32'd2);
         check("hold_cycles", out_res_cycles,     32'd12);
         check("hold_flag",   32'(out_res_flag),  32'(FLAG_LONG));
         check("hold_gnt",    32'(out_gnt),       32'd0);
         tick();
      end
      in_res_ready = 1'b1;
      tick();
      check("post_hs_gnt",    32'(out_gnt),       32'd0);
      check("post_hs_valid",  32'(out_res_valid), 32'd0);
      check("post_hs_cycles", out_res_cycles,     32'd12);
      tick();
      check("regrant_gnt", 32'(out_gnt), 32'b0100);

      // request dropped in RUN: abort, nothing reported
      in_req[2] = 1'b0;
      tick();
      check("abort_busy",  32'(out_busy),      32'd0);
      check("abort_valid", 32'(out_res_valid), 32'd0);
      tick();
      check("abort_valid2", 32'(out_res_valid), 32'd0);

      // bounds/timeout changed during RUN and foreign done pulse are ignored
      in_req[3] = 1'b1;
      tick();
      check("latch_gnt", 32'(out_gnt), 32'b1000);
      repeat (2) tick();
      in_lo_bound = 32'd0;
      in_hi_bound = 32'd1;
      in_timeout  = 32'd3;
      in_done[0]  = 1'b1;
      tick();
      in_done[0] = 1'b0;
      check("foreign_done_gnt", 32'(out_gnt), 32'b1000);
      repeat (5) tick();
      in_done[3] = 1'b1;
      push_exp(3, 8, FLAG_OK);
      tick();
      in_done[3]  = 1'b0;
      in_req[3]   = 1'b0;
      in_lo_bound = 32'd5;
      in_hi_bound = 32'd10;
      in_timeout  = 32'd0;
      wait_idle(10);

      // reset while a result is pending: pointer returns so requester 0 wins
      measure(0, 0, FLAG_SHORT);
      in_res_ready = 1'b0;
      in_req[1]    = 1'b1;
      tick();
      check("pre_rst_gnt", 32'(out_gnt), 32'b0010);
      repeat (3) tick();
      in_done[1] = 1'b1;
      tick();
      in_done[1] = 1'b0;
      check("pre_rst_valid",  32'(out_res_valid), 32'd1);
      check("pre_rst_cycles", out_res_cycles,     32'd3);
      in_reset_n = 1'b0;
      #1;
      check_reset_outputs();
      tick();
      in_reset_n   = 1'b1;
      in_res_ready = 1'b1;
      in_req       = 4'b0011;
      tick();
      check("post_rst_gnt", 32'(out_gnt), 32'b0001);
      in_done[0] = 1'b1;
      push_exp(0, 0, FLAG_SHORT);
      tick();
      in_done = '0;
      in_req  = '0;
      wait_idle(10);

      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/exec_window_ctrl.md
Name: exec_window_ctrl

Overview:
- Shares one execution-cycle measurement engine between NUM_REQ requesters using round-robin arbitration.
- For the granted requester it measures the cycles from grant to that requester's done pulse, then classifies the count against latched lower/upper bounds and a timeout.
- Each result is reported through a valid/ready handshake.
- Sits between the monitored execution units and the detection/alarm logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester index.
- CNT_W, 32, cycle counter width.

Ports:
- in_clk  input  1  clock, rising edge.
- in_reset_n  input  1  asynchronous, active-low reset.
- in_req  input  NUM_REQ  per-requester measurement request, level-sensitive.
- in_done  input  NUM_REQ  per-requester end-of-execution pulse.
- in_lo_bound  input  CNT_W  minimum legal cycle count.
- in_hi_bound  input  CNT_W  maximum legal cycle count.
- in_timeout  input  CNT_W  abort threshold; 0 disables the timeout.
- out_gnt  output  NUM_REQ  one-hot grant, asserted only in RUN.
- out_busy  output  1  high in any state other than IDLE.
- out_res_valid  output  1  result available.
- in_res_ready  input  1  consumer accepts the result.
- out_res_id  output  ID_W  index of the measured requester.
- out_res_cycles  output  CNT_W  measured cycle count.
- out_res_flag  output  2  00 OK, 01 SHORT, 10 LONG, 11 TIMEOUT.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State IDLE.
  - out_gnt = 0, out_busy = 0, out_res_valid = 0; out_res_id, out_res_cycles, out_res_flag all 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation discards any measurement or pending result without reporting it.
- States: IDLE, RUN, REPORT.
- IDLE:
  - If any in_req bit is high, select the winner: the first set bit searching upward from pointer+1, wrapping around.
  - On that edge: latch the winner id, in_lo_bound, in_hi_bound and in_timeout; clear the counter to 0; go to RUN.
  - out_gnt rises in the first RUN cycle (one cycle of grant latency).
  - Bound changes after latching have no effect until the next grant.
- RUN:
  - out_gnt[id] = 1.
  - Each cycle with in_done[id] = 0, the counter increments, saturating at all-ones.
  - in_done[id] = 1: capture the current count (0 if done arrives in the first RUN cycle) and go to REPORT.
  - Timeout: timeout != 0 and count == timeout with done low → capture count = timeout, flag TIMEOUT, go to REPORT.
  - Same-cycle done and timeout match: done wins and the result is classified normally.
  - in_done bits of non-granted requesters are ignored.
  - in_req[id] deasserted while in RUN: abort, no report, pointer still advances to id, return to IDLE the next cycle.
- Classification (non-timeout), priority order:
  - count > hi → LONG.
  - else count < lo → SHORT.
  - else OK.
  - lo > hi is legal; the priority order above resolves it.
- REPORT:
  - out_gnt = 0.
  - out_res_valid = 1; out_res_id, out_res_cycles and out_res_flag are held stable until valid && ready.
  - On the handshake edge: valid drops, pointer = id, go to IDLE.
  - A new grant happens no earlier than the cycle after returning to IDLE, so there is a minimum of 2 idle-to-idle gap cycles around each handshake.
- Result outputs keep their last values after the handshake until the next capture.

Decomposition:
- Shared package exec_mon_pkg:
  - Flag encodings FLAG_OK, FLAG_SHORT, FLAG_LONG, FLAG_TIMEOUT.
  - State enum with states IDLE, RUN, REPORT.
  - Default CNT_W.
- One sub-module, exec_rr_arbiter:
  - Parameterised round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner, winner index and an any-request flag.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset then in_req = 0001, bounds lo = 5, hi = 10, timeout = 0; done after 7 RUN cycles → gnt = 0001 one cycle after the request, res id = 0, cycles = 7, flag OK.
- in_req = 1111 held, immediate done each time, ready tied high → grants in order 0, 1, 2, 3, 0; every result has cycles = 0 and flag SHORT (lo = 5).
- timeout = 20, done never asserted → res cycles = 20, flag TIMEOUT; gnt drops in the REPORT cycle.
- Done at count 12 with hi = 10, in_res_ready held low 5 cycles → valid and data stable for 5 cycles, flag LONG, no new grant until the cycle after the handshake.
- Bounds changed while in RUN, and in_done pulsed on a non-granted requester → no effect on the measurement or the result.
- in_req[id] dropped in RUN, and in_reset_n asserted in REPORT → no result on abort; after reset, all outputs are 0 and requester 0 wins the next arbitration.
